system_sw_poller: RTL
=====================

Name: system_sw_poller

Overview:
Avalon-MM read master, the initiator side of the switch PIO slave. It periodically issues single-cycle reads to the PIO data register at address 0 and captures the low DATA_W bits of readdata. It debounces successive samples and publishes a stable switch value with per-bit change flags and a one-cycle change strobe. It lets fabric logic consume switch state without a CPU.

Parameters:
DATA_W, 10, width of switch field taken from readdata[DATA_W-1:0] (1..32)
POLL_DIV, 50000, WAIT-state cycles between reads (>=1)
STABLE_CNT, 4, consecutive identical samples required to accept a value (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  polling enable
avm_address  out  2  read address; constant 0
avm_read  out  1  read strobe, one cycle per poll
avm_readdata  in  32  slave readdata; valid the cycle after avm_read (fixed latency 1, no waitrequest)
sw_value  out  DATA_W  last accepted debounced value
sw_valid  out  1  high once a first value has been accepted
sw_changed  out  DATA_W  bits that differed at the last accepted change
change_pulse  out  1  one-cycle strobe on an accepted change

Behaviour:
- Reset (async, reset_n=0): state=WAIT, poll_cnt=0, avm_read=0, avm_address=0, sw_value=0, sw_valid=0, sw_changed=0, change_pulse=0, candidate=0, stable_cnt=0. avm_read drops immediately on reset assertion, even mid-REQ.
- FSM states: WAIT, REQ, CAP.
- WAIT: enable=1 increments poll_cnt. When poll_cnt==POLL_DIV-1, clear poll_cnt and go to REQ. enable=0 holds poll_cnt at 0 and stays in WAIT.
- REQ: avm_read=1, avm_address=0 for exactly one cycle, then go to CAP unconditionally.
- CAP: sample raw=avm_readdata[DATA_W-1:0], then return to WAIT. Bits above DATA_W are ignored.
- enable falling during REQ or CAP: the current poll completes; only WAIT honours enable.
- Poll period with enable held high: POLL_DIV+2 cycles between avm_read rising edges.
- Debounce, evaluated in CAP:
  - raw!=candidate: candidate<=raw, stable_cnt<=1.
  - raw==candidate: stable_cnt<=min(stable_cnt+1, STABLE_CNT), saturating.
  - Accept when the post-update stable_cnt==STABLE_CNT. With STABLE_CNT=1, every sample is accepted immediately.
- Accept handling (registers update at the end of CAP, visible the following cycle):
  - sw_valid=0: sw_value<=candidate, sw_valid<=1, sw_changed<=0, no change_pulse. The first value is an initialisation, not a change.
  - sw_valid=1 and candidate!=sw_value: sw_value<=candidate, sw_changed<=sw_value^candidate, change_pulse=1 for exactly one cycle.
  - Accept with candidate==sw_value: no output change, no pulse.
- sw_changed holds until the next accepted change.
- change_pulse is never asserted for two consecutive cycles.
- A bounce that reverts before STABLE_CNT samples produces no output activity.
- Reset mid-poll discards any partial debounce state. The first accepted value after reset is again silent.

Test Plan:
- Reset, POLL_DIV=8, STABLE_CNT=3, enable=1, readdata=0x2A5 constant -> avm_read pulses every 10 cycles; the 3rd CAP gives sw_value=0x2A5, sw_valid=1, change_pulse never asserted.
- From a stable 0x2A5, switch readdata to 0x0F0 -> change_pulse fires once, the cycle after the 3rd matching CAP; sw_changed=0x255; sw_value=0x0F0.
- Bounce pattern over successive samples 0x0F0,0x001,0x0F0,0x0F0,0x0F0 -> no pulse and sw_value stays 0x0F0. Repeat with 0x001,0x001,0x0F0 -> no pulse.
- readdata=0xFFFFF000 | 0x3FF -> sw_value=0x3FF; upper bits have no effect; avm_address is always 0.
- Drop enable during a REQ cycle -> REQ and CAP complete, no further avm_read while enable=0; raise enable -> next avm_read after exactly POLL_DIV WAIT cycles.
- Assert reset_n=0 in the REQ cycle -> avm_read=0 immediately and all outputs are 0; after release, the first accepted value is silent (sw_valid rises, no change_pulse).

Source files
------------

// File: rtl/system_sw_poller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | system_sw_poller_if : Avalon-MM read-only bus, switch PIO side      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface system_sw_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (output avm_address, output avm_read, input avm_readdata);
  modport slave  (input avm_address, input avm_read, output avm_readdata);
endinterface
`default_nettype wire

// File: rtl/system_sw_poller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | system_sw_poller : periodic Avalon-MM switch reader with debounce   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module system_sw_poller #(
  parameter int DATA_W     = 10,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              enable,
  system_sw_poller_if.master     avm,
  output logic [DATA_W-1:0]      sw_value,
  output logic                   sw_valid,
  output logic [DATA_W-1:0]      sw_changed,
  output logic                   change_pulse
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int STB_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] C_POLL_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [STB_W-1:0] C_STB_MAX   = STB_W'(STABLE_CNT);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_poll_cnt;
  logic [DATA_W-1:0] r_cand;
  logic [STB_W-1:0]  r_stable;
  logic [DATA_W-1:0] r_value;
  logic              r_valid;
  logic [DATA_W-1:0] r_changed;
  logic              r_pulse;

  logic              w_read;
  logic              w_cap;
  logic              w_poll_done;
  logic [DATA_W-1:0] w_raw;
  logic [STB_W-1:0]  w_stable_nxt;
  logic              w_accept;

  assign w_poll_done = enable && (r_poll_cnt == C_POLL_LAST);
  assign w_raw       = avm.avm_readdata[DATA_W-1:0];

  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^avm.avm_readdata[31:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (w_poll_done) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_WAIT;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w_read = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      S_REQ:   w_read = 1'b1;
      S_CAP:   w_cap  = 1'b1;
      default: ;
    endcase
  end

  assign avm.avm_read    = w_read;
  assign avm.avm_address = 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      if (!enable || w_poll_done) r_poll_cnt <= '0;
      else                        r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  // Count saturates so a long-stable input keeps re-accepting the same value harmlessly.
  always_comb begin
    if (w_raw != r_cand)              w_stable_nxt = STB_W'(1);
    else if (r_stable == C_STB_MAX)   w_stable_nxt = C_STB_MAX;
    else                              w_stable_nxt = r_stable + 1'b1;
  end

  assign w_accept = w_cap && (w_stable_nxt == C_STB_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand    <= '0;
      r_stable  <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_changed <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_cap) begin
        r_cand   <= w_raw;
        r_stable <= w_stable_nxt;
      end
      if (w_accept) begin
        if (!r_valid) begin
          r_value   <= w_raw;
          r_valid   <= 1'b1;
          r_changed <= '0;
        end else if (w_raw != r_value) begin
          r_value   <= w_raw;
          r_changed <= r_value ^ w_raw;
          r_pulse   <= 1'b1;
        end
      end
    end
  end

  assign sw_value     = r_value;
  assign sw_valid     = r_valid;
  assign sw_changed   = r_changed;
  assign change_pulse = r_pulse;

endmodule
`default_nettype wire
